fetch_byte_queue: RTL
=====================

Name: fetch_byte_queue

Overview:
- Instruction byte buffer between the byte-addressed instruction memory fetch and the x86 decode stage.
- Accepts 16-byte fetch lines tagged with their PC and stores them in a circular byte ring.
- Presents a 16-byte window starting at the oldest unconsumed byte to decode.
- Decode pops a variable instruction length (1..15) each cycle, which lets variable-length x86 instructions stream through without refetching.

Parameters:
- DEPTH_BYTES, 32: ring capacity in bytes; must be a power of two and at least 2*LINE_BYTES.
- LINE_BYTES, 16: bytes per fetch line written.
- WIN_BYTES, 16: bytes presented to decode.
- RESET_PC, 32'h0: head and tail PC after reset.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  redirect; discards all contents
- flush_pc  in  32  new head/tail PC on flush
- fetch_pc  out  32  address fetch must request next (= tail_pc)
- in_valid  in  1  fetch line valid
- in_ready  out  1  space for one full line
- in_data  in  128  line bytes; byte 0 in [7:0]
- in_pc  in  32  PC of in_data byte 0
- out_valid  out  1  out_count != 0
- out_window  out  128  bytes head..head+15; byte 0 in [7:0]
- out_pc  out  32  PC of out_window byte 0 (= head_pc)
- out_count  out  6  valid bytes in ring, 0..32
- consume  in  1  decode pops consume_len bytes
- consume_len  in  4  1..15
- err  out  1  one-cycle pulse on a dropped line or an illegal consume

Behaviour:
- Reset (async, rst=1):
  - head=tail=0, count=0, head_pc=tail_pc=RESET_PC.
  - err=0, out_valid=0, in_ready=1, out_window=all 8'h90.
- State: head ptr, tail ptr, count, head_pc, tail_pc, err.
  - Pointers are log2(DEPTH_BYTES) bits and wrap modulo DEPTH_BYTES.
  - PCs wrap modulo 2^32.
- in_ready = (DEPTH_BYTES - count >= LINE_BYTES) && !flush.
  - Combinational from registered count; it does not depend on consume in the same cycle.
- Push condition: in_valid && in_ready && in_pc == tail_pc.
  - Write 16 bytes at tail..tail+15 (wrapping); tail += 16; tail_pc += 16.
- Line mismatch: in_valid && in_ready && in_pc != tail_pc.
  - Line is dropped, state is unchanged, err=1 next cycle.
- Pop condition: consume && consume_len != 0 && consume_len <= count.
  - head += len; head_pc += len.
- Illegal pop: consume && (len == 0 || len > count).
  - Ignored, err=1 next cycle.
- Count update: count_next = count + 16*push - len*pop. A simultaneous push and pop are both applied.
- Flush has the highest priority:
  - Next cycle: head=tail=0, count=0, head_pc=tail_pc=flush_pc.
  - Push, pop and err generation are suppressed that cycle.
- Latency: a pushed byte appears on out_window on the edge after the write. There is no in-to-out bypass.
- out_window byte i:
  - ring[(head+i) mod DEPTH] when i < count, else 8'h90 (NOP).
  - Purely combinational from registered state.
- err is high only for the cycle following the offending event.

Decomposition:
- Shared package fetch_pkg holds:
  - LINE_BYTES, WIN_BYTES
  - NOP_BYTE = 8'h90
  - MAX_INSTR_LEN = 15
  - PC width 32
- One natural sub-module, fq_byte_ring:
  - storage with a 16-byte wrapping write port and a 16-byte wrapping read window;
  - no control logic, driven by head/tail/write-enable from the parent.

Test Plan:
1. Reset: hold rst 3 cycles, then release → out_valid=0, out_count=0, in_ready=1, fetch_pc=0, out_pc=0, out_window=16×90, err=0.
2. Single MOV:
   - Push in_pc=0 with bytes B8 EF BE AD DE followed by 11×90 → next cycle out_count=16, out_window[39:0]=40'hDEADBEEFB8, out_pc=0, fetch_pc=0x10.
   - Then consume_len=5 → out_pc=5, out_count=11, out_window[7:0]=90.
3. Full and wrap:
   - Push 2 lines (pc 0x0, 0x10) → count=32, in_ready=0; in_valid held without effect.
   - Consume 15, then 2 → count=15, in_ready=1.
   - Push pc 0x20 → written at ptr 0..15; out_window spans the wrap with byte 0 = byte at pc 0x11.
4. Simultaneous push and consume_len=5 at count=16 → count=27, out_pc +=5, tail_pc +=16.
5. Flush with flush_pc=0x100 in the same cycle as in_valid and consume=1 → next cycle count=0, out_valid=0, out_pc=0x100, fetch_pc=0x100, err=0.
6. Error handling:
   - in_pc=0x40 while tail_pc=0x30 → line dropped, count unchanged, err pulse of exactly 1 cycle.
   - consume_len=7 at count=5 → ignored, err pulse of 1 cycle.
   - Assert rst mid-stream → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch byte queue.
package fetch_pkg;

    localparam int unsigned LINE_BYTES    = 16;
    localparam int unsigned WIN_BYTES     = 16;
    localparam int unsigned MAX_INSTR_LEN = 15;
    localparam int unsigned PC_W          = 32;

    localparam logic [7:0] NOP_BYTE = 8'h90;

    typedef logic [PC_W-1:0] pc_t;

endpackage

// File: rtl/fq_byte_ring.sv
// Byte ring storage: one line-wide wrapping write port and one window-wide
// wrapping read port. Pointer arithmetic wraps naturally at PTR_W bits.
module fq_byte_ring
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 32
) (
    input  logic                          clk,
    input  logic                          i_we,
    input  logic [$clog2(DEPTH_BYTES)-1:0] i_wptr,
    input  logic [LINE_BYTES*8-1:0]       i_wdata,
    input  logic [$clog2(DEPTH_BYTES)-1:0] i_rptr,
    output logic [WIN_BYTES*8-1:0]        o_window
);

    localparam int unsigned PTR_W = $clog2(DEPTH_BYTES);

    logic [7:0] r_mem [DEPTH_BYTES];

    // Write one full line starting at the write pointer, wrapping at the end
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < LINE_BYTES; i++) begin
                r_mem[PTR_W'(i_wptr + PTR_W'(i))] <= i_wdata[i*8 +: 8];
            end
        end
    end

    // Gather the raw window starting at the read pointer, wrapping at the end
    always_comb begin
        o_window = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            o_window[i*8 +: 8] = r_mem[PTR_W'(i_rptr + PTR_W'(i))];
        end
    end

endmodule

// File: rtl/fetch_byte_queue.sv
// Instruction byte queue between line fetch and variable-length x86 decode.
// Fetch pushes 16-byte PC-tagged lines; decode pops 1..15 bytes per cycle.
module fetch_byte_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     DEPTH_BYTES = 32,
    parameter logic [PC_W-1:0] RESET_PC    = 32'h0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [PC_W-1:0]                        flush_pc,
    output logic [PC_W-1:0]                        fetch_pc,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [LINE_BYTES*8-1:0]                in_data,
    input  logic [PC_W-1:0]                        in_pc,
    output logic                                   out_valid,
    output logic [WIN_BYTES*8-1:0]                 out_window,
    output logic [PC_W-1:0]                        out_pc,
    output logic [$clog2(DEPTH_BYTES):0]           out_count,
    input  logic                                   consume,
    input  logic [$clog2(MAX_INSTR_LEN+1)-1:0]     consume_len,
    output logic                                   err
);

    // DEPTH_BYTES must be a power of two and at least two lines deep.
    localparam int unsigned PTR_W = $clog2(DEPTH_BYTES);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    pc_t              r_head_pc;
    pc_t              r_tail_pc;
    logic             r_err;

    logic                   w_in_ready;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_len_ok;
    logic                   w_pop;
    logic                   w_bad_pop;
    logic [CNT_W-1:0]       w_count_next;
    logic [WIN_BYTES*8-1:0] w_raw_window;

    // Push/pop qualification; flush suppresses both and any error report
    always_comb begin
        w_in_ready   = (r_count <= CNT_W'(DEPTH_BYTES - LINE_BYTES)) && !flush;
        w_push       = in_valid && w_in_ready && (in_pc == r_tail_pc);
        w_drop       = in_valid && w_in_ready && (in_pc != r_tail_pc);
        w_len_ok     = (consume_len != '0) && (CNT_W'(consume_len) <= r_count);
        w_pop        = consume && w_len_ok && !flush;
        w_bad_pop    = consume && !w_len_ok && !flush;
        w_count_next = r_count
                     + (w_push ? CNT_W'(LINE_BYTES) : '0)
                     - (w_pop  ? CNT_W'(consume_len) : '0);
    end

    // Pointer, occupancy, PC and error state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_head_pc <= RESET_PC;
            r_tail_pc <= RESET_PC;
            r_err     <= 1'b0;
        end else if (flush) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_head_pc <= flush_pc;
            r_tail_pc <= flush_pc;
            r_err     <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail    <= r_tail + PTR_W'(LINE_BYTES);
                r_tail_pc <= r_tail_pc + PC_W'(LINE_BYTES);
            end
            if (w_pop) begin
                r_head    <= r_head + PTR_W'(consume_len);
                r_head_pc <= r_head_pc + PC_W'(consume_len);
            end
            r_count <= w_count_next;
            r_err   <= w_drop | w_bad_pop;
        end
    end

    fq_byte_ring #(
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_ring (
        .clk      (clk),
        .i_we     (w_push),
        .i_wptr   (r_tail),
        .i_wdata  (in_data),
        .i_rptr   (r_head),
        .o_window (w_raw_window)
    );

    // Bytes beyond the valid count read as NOP so decode never sees stale data
    always_comb begin
        out_window = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            out_window[i*8 +: 8] = (CNT_W'(i) < r_count) ? w_raw_window[i*8 +: 8] : NOP_BYTE;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_count != '0);
    assign out_count = r_count;
    assign out_pc    = r_head_pc;
    assign fetch_pc  = r_tail_pc;
    assign err       = r_err;

endmodule
